lcd1602_driver: RTL and testbench

Consumes the two 128-bit display rows (`top`, `bottom`) produced by the host game-display logic and drives a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus. Runs the power-up initialisation sequence, then writes both rows as 34 bus transactions (2 address commands plus 32 characters). After the first frame it re-writes the display only when the row inputs change. It sits between the host display logic and the board LCD pins.

---
 rtl/lcd_pkg.sv | 58 +++++
 rtl/lcd1602_driver_strobe.sv | 101 ++++++++++
 rtl/lcd1602_driver.sv | 183 ++++++++++++++++++
 tb/tb_lcd1602_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types, HD44780 command bytes and helpers for the
//               16x2 character LCD driver.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Top-level sequencer states; the state names the byte currently in flight.
    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_ADDR0   = 3'd3,
        ST_ROW0    = 3'd4,
        ST_ADDR1   = 3'd5,
        ST_ROW1    = 3'd6,
        ST_IDLE    = 3'd7
    } lcd_state_e;

    // Phases of a single bus byte transaction.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_HIGH  = 2'd2,
        PH_WAIT  = 2'd3
    } strobe_phase_e;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ROW0_ADDR = 8'h80;
    localparam logic [7:0] ROW1_ADDR = 8'hC0;
    localparam logic [7:0] SPACE     = 8'h20;

    // Initialisation command by position in the power-up sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY;
            default: return CLEAR;
        endcase
    endfunction

    // Column c of a row lives at row[127-8c -: 8]; NUL bytes display as blanks.
    function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] col);
        logic [6:0] msb;
        logic [7:0] b;
        msb = 7'd127 - {col, 3'b000};
        b   = row[msb -: 8];
        return (b == 8'h00) ? SPACE : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd1602_driver_strobe.sv
`default_nettype none
// ============================================================================
// Module      : lcd_byte_strobe
// Description : Drives one LCD bus byte: one setup cycle, EN_CYC cycles of
//               enable high, then a caller-chosen number of enable-low wait
//               cycles. done pulses in the last wait cycle so the caller can
//               chain the next byte with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_byte_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC = 10
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        start_i,
    input  logic        rs_i,
    input  logic [7:0]  byte_i,
    input  logic [31:0] wait_cyc_i,
    output logic        lcd_rs_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o,
    output logic        done_o
);

    strobe_phase_e phase_q, phase_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   wait_q, wait_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic [7:0]    data_q, data_d;

    // Phase register and latched bus byte; reset clears the bus at once.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= 32'd0;
            wait_q  <= 32'd0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    // Phase sequencing; a start request always wins and reloads the bus.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        rs_d    = rs_q;
        en_d    = en_q;
        data_d  = data_q;
        done_o  = (phase_q == PH_WAIT) && (cnt_q == wait_q);
        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_HIGH;
                en_d    = 1'b1;
                cnt_d   = 32'd1;
            end
            PH_HIGH: begin
                if (cnt_q == EN_CYC) begin
                    phase_d = PH_WAIT;
                    en_d    = 1'b0;
                    cnt_d   = 32'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            PH_WAIT: begin
                if (done_o) begin
                    phase_d = PH_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: ;
        endcase
        if (start_i) begin
            phase_d = PH_SETUP;
            rs_d    = rs_i;
            data_d  = byte_i;
            wait_d  = wait_cyc_i;
            en_d    = 1'b0;
            cnt_d   = 32'd0;
        end
    end

    assign lcd_rs_o   = rs_q;
    assign lcd_en_o   = en_q;
    assign lcd_data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/lcd1602_driver.sv
`default_nettype none
// ============================================================================
// Module      : lcd1602_driver
// Description : Initialises a 16x2 HD44780 LCD and writes both rows from
//               shadow copies of the host row buffers, re-writing whenever
//               the host rows change.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd1602_driver
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = 400_000,
    parameter int unsigned EN_CYC         = 10,
    parameter int unsigned CMD_WAIT_CYC   = 500,
    parameter int unsigned CLEAR_WAIT_CYC = 20_000
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [127:0] top,
    input  logic [127:0] bottom,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         busy
);

    lcd_state_e   state_q, state_d;
    logic [3:0]   col_q, col_d;
    logic [31:0]  pwr_q, pwr_d;
    logic [127:0] sh_top_q, sh_top_d;
    logic [127:0] sh_bot_q, sh_bot_d;
    logic         dirty_q, dirty_d;

    logic         st_start;
    logic         st_rs;
    logic [7:0]   st_byte;
    logic [31:0]  st_wait;
    logic         st_done;

    // Sequencer state, column/init index, power-up timer, shadows and dirty flag.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_POWERUP;
            col_q    <= 4'd0;
            pwr_q    <= 32'd0;
            sh_top_q <= '0;
            sh_bot_q <= '0;
            dirty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            pwr_q    <= pwr_d;
            sh_top_q <= sh_top_d;
            sh_bot_q <= sh_bot_d;
            dirty_q  <= dirty_d;
        end
    end

    // Next byte is requested in the cycle the previous one reports done,
    // so transactions run back to back; LATCH overlaps the 0x80 setup cycle.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        pwr_d    = pwr_q;
        sh_top_d = sh_top_q;
        sh_bot_d = sh_bot_q;
        dirty_d  = dirty_q | ({top, bottom} != {sh_top_q, sh_bot_q});
        st_start = 1'b0;
        st_rs    = 1'b0;
        st_byte  = 8'h00;
        case (state_q)
            ST_POWERUP: begin
                pwr_d = pwr_q + 32'd1;
                if (pwr_q == POWERUP_CYC) begin
                    st_start = 1'b1;
                    st_byte  = init_cmd(2'd0);
                    col_d    = 4'd0;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                if (st_done) begin
                    st_start = 1'b1;
                    if (col_q == 4'd3) begin
                        st_byte = ROW0_ADDR;
                        col_d   = 4'd0;
                        state_d = ST_LATCH;
                    end else begin
                        st_byte = init_cmd(col_q[1:0] + 2'd1);
                        col_d   = col_q + 4'd1;
                    end
                end
            end
            ST_LATCH: begin
                sh_top_d = top;
                sh_bot_d = bottom;
                dirty_d  = 1'b0;
                state_d  = ST_ADDR0;
            end
            ST_ADDR0: begin
                if (st_done) begin
                    st_start = 1'b1;
                    st_rs    = 1'b1;
                    st_byte  = row_char(sh_top_q, 4'd0);
                    col_d    = 4'd0;
                    state_d  = ST_ROW0;
                end
            end
            ST_ROW0: begin
                if (st_done) begin
                    st_start = 1'b1;
                    if (col_q == 4'd15) begin
                        st_byte = ROW1_ADDR;
                        col_d   = 4'd0;
                        state_d = ST_ADDR1;
                    end else begin
                        st_rs   = 1'b1;
                        st_byte = row_char(sh_top_q, col_q + 4'd1);
                        col_d   = col_q + 4'd1;
                    end
                end
            end
            ST_ADDR1: begin
                if (st_done) begin
                    st_start = 1'b1;
                    st_rs    = 1'b1;
                    st_byte  = row_char(sh_bot_q, 4'd0);
                    col_d    = 4'd0;
                    state_d  = ST_ROW1;
                end
            end
            ST_ROW1: begin
                if (st_done) begin
                    if (col_q == 4'd15) begin
                        col_d = 4'd0;
                        if (dirty_q) begin
                            st_start = 1'b1;
                            st_byte  = ROW0_ADDR;
                            state_d  = ST_LATCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        st_start = 1'b1;
                        st_rs    = 1'b1;
                        st_byte  = row_char(sh_bot_q, col_q + 4'd1);
                        col_d    = col_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (dirty_q) begin
                    st_start = 1'b1;
                    st_byte  = ROW0_ADDR;
                    state_d  = ST_LATCH;
                end
            end
            default: state_d = ST_POWERUP;
        endcase
        st_wait = (!st_rs && (st_byte == CLEAR)) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
    end

    lcd_byte_strobe #(
        .EN_CYC (EN_CYC)
    ) u_strobe (
        .clk        (clk),
        .nRst       (nRst),
        .start_i    (st_start),
        .rs_i       (st_rs),
        .byte_i     (st_byte),
        .wait_cyc_i (st_wait),
        .lcd_rs_o   (lcd_rs),
        .lcd_en_o   (lcd_en),
        .lcd_data_o (lcd_data),
        .done_o     (st_done)
    );

    assign lcd_rw = 1'b0;
    assign busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd1602_driver
// Description : Directed self-checking bench for lcd1602_driver. A monitor
//               records every lcd_en rising edge with its cycle number and
//               {rs,data}; scenario tasks compare against hand-built frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd1602_driver;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [127:0] top = '0;
    logic [127:0] bottom = '0;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic [7:0]   lcd_data;
    logic         busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [8:0] ev;
    } ev_t;
    ev_t  evq[$];
    int   cyc = -1;
    logic en_prev = 1'b0;

    lcd1602_driver #(
        .POWERUP_CYC    (20),
        .EN_CYC         (2),
        .CMD_WAIT_CYC   (4),
        .CLEAR_WAIT_CYC (10)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .top      (top),
        .bottom   (bottom),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first rising edge with nRst high; sample 1 time unit later.
    always @(posedge clk) begin
        ev_t e;
        if (!nRst) cyc = -1;
        else       cyc = cyc + 1;
        #1;
        if (!nRst) begin
            en_prev = 1'b0;
        end else begin
            if (lcd_en && !en_prev) begin
                e.cyc = cyc;
                e.ev  = {lcd_rs, lcd_data};
                evq.push_back(e);
            end
            en_prev = lcd_en;
        end
    end

    // Expected {rs,data} of transaction k (0..33) of a frame built from t/b.
    function automatic logic [8:0] exp_ev(input int k, input logic [127:0] t, input logic [127:0] b);
        logic [7:0] c;
        if (k == 0)  return {1'b0, 8'h80};
        if (k == 17) return {1'b0, 8'hC0};
        if (k <= 16) c = 8'(t >> (8 * (16 - k)));
        else         c = 8'(b >> (8 * (33 - k)));
        if (c == 8'h00) c = 8'h20;
        return {1'b1, c};
    endfunction

    task automatic wait_events(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (evq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        nRst   = 1'b0;
        top    = {8'h48, 8'h41, 8'h4E, 8'h47, 8'h4D, 8'h41, 8'h4E, 72'h0};
        bottom = {16{8'h5F}};
        repeat (3) @(posedge clk);
        #2;
        checks++; if (lcd_en !== 1'b0)    begin failures++; $display("FAIL reset_en got=%b exp=0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0)    begin failures++; $display("FAIL reset_rs got=%b exp=0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0)    begin failures++; $display("FAIL reset_rw got=%b exp=0", lcd_rw); end
        checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", lcd_data); end
        checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    endtask

    task automatic test_powerup;
        bit ok;
        logic [7:0] cmds [4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        evq.delete();
        @(negedge clk);
        nRst = 1'b1;
        wait_events(5, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL powerup_timeout got=%0d events exp=5", evq.size());
            return;
        end
        checks++; if (evq[0].cyc != 21) begin failures++; $display("FAIL powerup_first_en got=%0d exp=21", evq[0].cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evq[i].ev !== {1'b0, cmds[i]}) begin
                failures++; $display("FAIL init_cmd%0d got=%h exp=%h", i, evq[i].ev, {1'b0, cmds[i]});
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (evq[i].cyc - evq[i-1].cyc != 7) begin
                failures++; $display("FAIL init_gap%0d got=%0d exp=7", i, evq[i].cyc - evq[i-1].cyc);
            end
        end
        checks++; if (evq[4].cyc - evq[3].cyc != 13) begin failures++; $display("FAIL clear_gap got=%0d exp=13", evq[4].cyc - evq[3].cyc); end
    endtask

    task automatic test_first_frame;
        bit ok;
        wait_events(38, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL frame_timeout got=%0d events exp=38", evq.size());
            return;
        end
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (evq[4+k].ev !== exp_ev(k, top, bottom)) begin
                failures++; $display("FAIL frame_byte%0d got=%h exp=%h", k, evq[4+k].ev, exp_ev(k, top, bottom));
            end
        end
        for (int k = 1; k < 34; k++) begin
            checks++;
            if (evq[4+k].cyc - evq[3+k].cyc != 7) begin
                failures++; $display("FAIL frame_gap%0d got=%0d exp=7", k, evq[4+k].cyc - evq[3+k].cyc);
            end
        end
        wait_not_busy(ok);
        checks++; if (!ok) begin failures++; $display("FAIL frame_busy_fall got=%b exp=0", busy); end
        checks++; if (evq.size() != 38) begin failures++; $display("FAIL frame_extra got=%0d exp=38", evq.size()); end
    endtask

    task automatic test_idle;
        int n0;
        n0 = evq.size();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (lcd_en !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL idle_cycle%0d got en=%b busy=%b exp en=0 busy=0", i, lcd_en, busy);
                break;
            end
        end
        checks++; if (evq.size() != n0) begin failures++; $display("FAIL idle_strobes got=%0d exp=%0d", evq.size(), n0); end
    endtask

    task automatic test_change_mid_frame;
        bit ok;
        int base;
        logic [127:0] old_top;
        base    = evq.size();
        old_top = top;
        bottom  = {16{8'h41}};
        wait_events(base + 19, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL change_start_timeout got=%0d exp=%0d", evq.size(), base + 19);
            return;
        end
        top[127:120] = 8'h57;
        wait_events(base + 68, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL change_end_timeout got=%0d exp=%0d", evq.size(), base + 68);
            return;
        end
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (evq[base+k].ev !== exp_ev(k, old_top, bottom)) begin
                failures++; $display("FAIL cur_frame_byte%0d got=%h exp=%h", k, evq[base+k].ev, exp_ev(k, old_top, bottom));
            end
            checks++;
            if (evq[base+34+k].ev !== exp_ev(k, top, bottom)) begin
                failures++; $display("FAIL new_frame_byte%0d got=%h exp=%h", k, evq[base+34+k].ev, exp_ev(k, top, bottom));
            end
        end
        checks++;
        if (evq[base+34].cyc - evq[base+33].cyc != 7) begin
            failures++; $display("FAIL back_to_back_gap got=%0d exp=7", evq[base+34].cyc - evq[base+33].cyc);
        end
        wait_not_busy(ok);
        checks++; if (!ok) begin failures++; $display("FAIL change_busy_fall got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int base;
        base = evq.size();
        top[127:120] = 8'h4B;
        wait_events(base + 3, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL midreset_timeout got=%0d exp=%0d", evq.size(), base + 3);
            return;
        end
        checks++; if (lcd_en !== 1'b1) begin failures++; $display("FAIL midreset_pre_en got=%b exp=1", lcd_en); end
        nRst = 1'b0;
        #1;
        checks++; if (lcd_en !== 1'b0)    begin failures++; $display("FAIL midreset_en got=%b exp=0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0)    begin failures++; $display("FAIL midreset_rs got=%b exp=0", lcd_rs); end
        checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL midreset_data got=%h exp=00", lcd_data); end
        checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL midreset_busy got=%b exp=1", busy); end
        repeat (3) @(posedge clk);
        test_powerup();
        test_first_frame();
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_first_frame();
        test_idle();
        test_change_mid_frame();
        test_reset_mid_frame();
        checks++; if (lcd_rw !== 1'b0) begin failures++; $display("FAIL rw_const got=%b exp=0", lcd_rw); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
